// File: rtl/gate_test_pkg.sv
// Shared definitions for the two-input gate-array test path: checker state
// encoding, gate vector layout and the golden truth-table function.
package gate_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int GATE_W = 7;
    localparam int CNT_W  = 8;

    // Bit positions inside the {p,q,r,s,t,u,v} vector (p is the MSB).
    localparam int BIT_P = 6;
    localparam int BIT_Q = 5;
    localparam int BIT_R = 4;
    localparam int BIT_S = 3;
    localparam int BIT_T = 2;
    localparam int BIT_U = 1;
    localparam int BIT_V = 0;

    function automatic logic [GATE_W-1:0] gate_expect(input logic a, input logic b);
        logic [GATE_W-1:0] g;
        g        = '0;
        g[BIT_P] = a & b;
        g[BIT_Q] = a | b;
        g[BIT_R] = ~(a & b);
        g[BIT_S] = ~(a | b);
        g[BIT_T] = a ^ b;
        g[BIT_U] = ~(a ^ b);
        g[BIT_V] = ~a;
        return g;
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden reference: maps a stimulus pair to the seven
// expected gate outputs.
module gate_golden_model
    import gate_test_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] exp_vec
);

    assign exp_vec = gate_expect(a, b);

endmodule

// File: rtl/gate_response_checker.sv
// Receive/compare end of the gate-array self-test: latches each applied
// vector, waits for the outputs to settle, compares and accumulates results.
module gate_response_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             p,
    input  logic             q,
    input  logic             r,
    input  logic             s,
    input  logic             t,
    input  logic             u,
    input  logic             v,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       cov_mask,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_bits,
    output logic             mismatch,
    output logic             overrun,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_SAT     = {ERR_W{1'b1}};

    // vec_valid and start are single-cycle pulses with no back-pressure:
    // vec_valid is accepted only in ARMED; a pulse in SETTLE/COMPARE is
    // dropped and flagged as overrun, and start is honoured only in IDLE/DONE.

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                la_q, la_d;
    logic                lb_q, lb_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [3:0]          cov_q, cov_d;
    logic [1:0]          ffv_q, ffv_d;
    logic [GATE_W-1:0]   ffb_q, ffb_d;
    logic                flag_q, flag_d;
    logic                overrun_q, overrun_d;
    logic                mismatch_q, mismatch_d;

    logic [GATE_W-1:0]   exp_vec;
    logic [GATE_W-1:0]   live_vec;
    logic [GATE_W-1:0]   diff;
    logic [3:0]          cov_hit;
    logic [3:0]          cov_upd;

    gate_golden_model u_golden (
        .a       (la_q),
        .b       (lb_q),
        .exp_vec (exp_vec)
    );

    assign live_vec = {p, q, r, s, t, u, v};
    assign diff     = exp_vec ^ live_vec;
    assign cov_hit  = 4'b0001 << {lb_q, la_q};
    assign cov_upd  = cov_q | cov_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            la_q       <= 1'b0;
            lb_q       <= 1'b0;
            err_q      <= '0;
            cov_q      <= '0;
            ffv_q      <= '0;
            ffb_q      <= '0;
            flag_q     <= 1'b0;
            overrun_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            la_q       <= la_d;
            lb_q       <= lb_d;
            err_q      <= err_d;
            cov_q      <= cov_d;
            ffv_q      <= ffv_d;
            ffb_q      <= ffb_d;
            flag_q     <= flag_d;
            overrun_q  <= overrun_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        la_d       = la_q;
        lb_d       = lb_q;
        err_d      = err_q;
        cov_d      = cov_q;
        ffv_d      = ffv_q;
        ffb_d      = ffb_q;
        flag_d     = flag_q;
        overrun_d  = overrun_q;
        mismatch_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d     = '0;
                    cov_d     = '0;
                    ffv_d     = '0;
                    ffb_d     = '0;
                    flag_d    = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vec_valid) begin
                    la_d = a;
                    lb_d = b;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_COMPARE;
                    end else begin
                        cnt_d   = SETTLE_INIT;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = ST_COMPARE;
                end
                if (vec_valid) begin
                    overrun_d = 1'b1;
                end
            end
            ST_COMPARE: begin
                if (vec_valid) begin
                    overrun_d = 1'b1;
                end
                if (diff != '0) begin
                    mismatch_d = 1'b1;
                    if (err_q != ERR_SAT) begin
                        err_d = err_q + 1'b1;
                    end
                    // Only the first failing vector of a run is kept.
                    if (!flag_q) begin
                        ffv_d  = {lb_q, la_q};
                        ffb_d  = diff;
                        flag_d = 1'b1;
                    end
                end
                cov_d   = cov_upd;
                state_d = (cov_upd == 4'b1111) ? ST_DONE : ST_ARMED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy            = (state_q == ST_ARMED) || (state_q == ST_SETTLE) ||
                             (state_q == ST_COMPARE);
    assign done            = (state_q == ST_DONE);
    assign pass            = done && (err_q == '0) && !overrun_q;
    assign err_count       = err_q;
    assign cov_mask        = cov_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_bits = ffb_q;
    assign mismatch        = mismatch_q;
    assign overrun         = overrun_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: three instances (settle 4,
// 2-bit error counter, settle 0) driven by a fault-injectable gate model.
module tb_gate_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_s [3];
    logic       vv_s    [3];
    logic       a_s     [3];
    logic       b_s     [3];
    logic [6:0] sa0_m   [3];
    logic [6:0] inv_m   [3];
    logic [6:0] g_out   [3];

    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic       mm_o   [3];
    logic       ovr_o  [3];
    logic [3:0] cov_o  [3];
    logic [1:0] ffv_o  [3];
    logic [6:0] ffb_o  [3];
    logic [2:0] dbg_o  [3];
    logic [7:0] err_o0, err_o2;
    logic [1:0] err_o1;

    // Reference model of the run, one slot per instance.
    int       settle_c [3] = '{4, 4, 0};
    int       err_max  [3] = '{255, 3, 255};
    int       m_err    [3];
    bit [3:0] m_cov    [3];
    bit [1:0] m_ffv    [3];
    bit [6:0] m_ffb    [3];
    bit       m_flag   [3];
    bit       m_ovr    [3];
    bit       m_run    [3];
    bit       m_done   [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [6:0] ref_gates(input logic a, input logic b);
        int  ai, bi;
        bit  and_o, or_o, xor_o;
        ai    = int'(a);
        bi    = int'(b);
        and_o = (ai * bi) == 1;
        or_o  = (ai + bi) > 0;
        xor_o = (ai + bi) == 1;
        return {and_o, or_o, !and_o, !or_o, xor_o, !xor_o, ai == 0};
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            g_out[i] = (ref_gates(a_s[i], b_s[i]) & ~sa0_m[i]) ^ inv_m[i];
        end
    end

    gate_response_checker #(.SETTLE_CYCLES(4), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .vec_valid(vv_s[0]),
        .a(a_s[0]), .b(b_s[0]),
        .p(g_out[0][6]), .q(g_out[0][5]), .r(g_out[0][4]), .s(g_out[0][3]),
        .t(g_out[0][2]), .u(g_out[0][1]), .v(g_out[0][0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o0),
        .cov_mask(cov_o[0]), .first_fail_vec(ffv_o[0]), .first_fail_bits(ffb_o[0]),
        .mismatch(mm_o[0]), .overrun(ovr_o[0]), .dbg_state(dbg_o[0])
    );

    gate_response_checker #(.SETTLE_CYCLES(4), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .vec_valid(vv_s[1]),
        .a(a_s[1]), .b(b_s[1]),
        .p(g_out[1][6]), .q(g_out[1][5]), .r(g_out[1][4]), .s(g_out[1][3]),
        .t(g_out[1][2]), .u(g_out[1][1]), .v(g_out[1][0]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o1),
        .cov_mask(cov_o[1]), .first_fail_vec(ffv_o[1]), .first_fail_bits(ffb_o[1]),
        .mismatch(mm_o[1]), .overrun(ovr_o[1]), .dbg_state(dbg_o[1])
    );

    gate_response_checker #(.SETTLE_CYCLES(0), .ERR_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .vec_valid(vv_s[2]),
        .a(a_s[2]), .b(b_s[2]),
        .p(g_out[2][6]), .q(g_out[2][5]), .r(g_out[2][4]), .s(g_out[2][3]),
        .t(g_out[2][2]), .u(g_out[2][1]), .v(g_out[2][0]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(err_o2),
        .cov_mask(cov_o[2]), .first_fail_vec(ffv_o[2]), .first_fail_bits(ffb_o[2]),
        .mismatch(mm_o[2]), .overrun(ovr_o[2]), .dbg_state(dbg_o[2])
    );

    function automatic logic [31:0] obs_err(input int k);
        case (k)
            0:       return 32'(err_o0);
            1:       return 32'(err_o1);
            default: return 32'(err_o2);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input int k, input logic exp_mm, input string tag);
        chk({tag, ".busy"},  k, 32'(busy_o[k]), 32'(m_run[k]));
        chk({tag, ".done"},  k, 32'(done_o[k]), 32'(m_done[k]));
        chk({tag, ".pass"},  k, 32'(pass_o[k]),
            32'(m_done[k] && m_err[k] == 0 && !m_ovr[k]));
        chk({tag, ".err"},   k, obs_err(k), 32'(m_err[k]));
        chk({tag, ".cov"},   k, 32'(cov_o[k]), 32'(m_cov[k]));
        chk({tag, ".ffv"},   k, 32'(ffv_o[k]), 32'(m_ffv[k]));
        chk({tag, ".ffb"},   k, 32'(ffb_o[k]), 32'(m_ffb[k]));
        chk({tag, ".ovr"},   k, 32'(ovr_o[k]), 32'(m_ovr[k]));
        chk({tag, ".mm"},    k, 32'(mm_o[k]), 32'(exp_mm));
    endtask

    task automatic model_clear(input int k);
        m_err[k]  = 0;
        m_cov[k]  = '0;
        m_ffv[k]  = '0;
        m_ffb[k]  = '0;
        m_flag[k] = 1'b0;
        m_ovr[k]  = 1'b0;
    endtask

    task automatic model_reset_all();
        for (int k = 0; k < 3; k++) begin
            model_clear(k);
            m_run[k]  = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            vv_s[k]    = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset_all();
        for (int k = 0; k < 3; k++) check_all(k, 1'b0, "reset");
    endtask

    task automatic start_run(input int k, input bit with_vv);
        @(negedge clk);
        start_s[k] = 1'b1;
        vv_s[k]    = with_vv;
        @(negedge clk);
        start_s[k] = 1'b0;
        vv_s[k]    = 1'b0;
        if (!m_run[k]) begin
            model_clear(k);
            m_run[k]  = 1'b1;
            m_done[k] = 1'b0;
        end
        check_all(k, 1'b0, "start");
    endtask

    // Applies one vector; extra in 1..settle+1 re-pulses vec_valid mid-flight.
    task automatic apply_vec(input int k, input logic a, input logic b,
                             input int extra, input int gap);
        int       s;
        bit       accepted;
        bit [6:0] gold, seen, diff;
        s        = settle_c[k];
        accepted = m_run[k];
        gold     = ref_gates(a, b);
        seen     = (gold & ~sa0_m[k]) ^ inv_m[k];
        diff     = gold ^ seen;
        @(negedge clk);
        a_s[k]  = a;
        b_s[k]  = b;
        vv_s[k] = 1'b1;
        for (int c = 1; c <= gap; c++) begin
            @(negedge clk);
            vv_s[k] = (accepted && c == extra);
            if (accepted && c == extra) m_ovr[k] = 1'b1;
            if (!accepted) begin
                check_all(k, 1'b0, "ignored");
            end else if (c < s + 2) begin
                chk("pre.busy", k, 32'(busy_o[k]), 32'd1);
                chk("pre.done", k, 32'(done_o[k]), 32'd0);
                chk("pre.mm",   k, 32'(mm_o[k]),   32'd0);
            end else if (c == s + 2) begin
                if (diff != 0) begin
                    m_err[k] = (m_err[k] + 1 > err_max[k]) ? err_max[k] : m_err[k] + 1;
                    if (!m_flag[k]) begin
                        m_ffv[k]  = {b, a};
                        m_ffb[k]  = diff;
                        m_flag[k] = 1'b1;
                    end
                end
                m_cov[k][{b, a}] = 1'b1;
                if (m_cov[k] == 4'b1111) begin
                    m_done[k] = 1'b1;
                    m_run[k]  = 1'b0;
                end
                check_all(k, diff != 0, "compare");
            end else begin
                chk("post.mm",   k, 32'(mm_o[k]),   32'd0);
                chk("post.done", k, 32'(done_o[k]), 32'(m_done[k]));
            end
        end
        vv_s[k] = 1'b0;
    endtask

    task automatic full_seq(input int k, input int gap);
        apply_vec(k, 1'b0, 1'b0, 0, gap);
        apply_vec(k, 1'b1, 1'b0, 0, gap);
        apply_vec(k, 1'b0, 1'b1, 0, gap);
        apply_vec(k, 1'b1, 1'b1, 0, gap);
    endtask

    initial begin
        int k, s, steps, vec, extra;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            vv_s[i]    = 1'b0;
            a_s[i]     = 1'b0;
            b_s[i]     = 1'b0;
            sa0_m[i]   = '0;
            inv_m[i]   = '0;
        end
        model_reset_all();
        do_reset();

        // vec_valid while IDLE is ignored and leaves overrun clear.
        apply_vec(1, 1'b1, 1'b0, 0, 3);

        // Correct gates, settle 4: done six cycles after the last vector.
        start_run(0, 1'b0);
        full_seq(0, 10);
        chk("t1.pass", 0, 32'(pass_o[0]), 32'd1);

        // p stuck-at-0: single failure at a=1,b=1.
        sa0_m[0] = 7'b1000000;
        start_run(0, 1'b0);
        full_seq(0, 10);
        chk("t2.ffv", 0, 32'(ffv_o[0]), 32'h3);
        chk("t2.ffb", 0, 32'(ffb_o[0]), 32'h40);
        sa0_m[0] = '0;

        // 2-bit counter, v inverted, repeated first vector.
        inv_m[1] = 7'b0000001;
        start_run(1, 1'b0);
        apply_vec(1, 1'b0, 1'b0, 0, 10);
        apply_vec(1, 1'b0, 1'b0, 0, 10);
        apply_vec(1, 1'b1, 1'b0, 0, 10);
        apply_vec(1, 1'b0, 1'b1, 0, 10);
        chk("t3.notdone", 1, 32'(done_o[1]), 32'd0);
        apply_vec(1, 1'b1, 1'b1, 0, 10);
        chk("t3.err_sat", 1, obs_err(1), 32'd3);
        apply_vec(1, 1'b1, 1'b1, 0, 3);

        // Second vec_valid two cycles into SETTLE.
        start_run(0, 1'b0);
        apply_vec(0, 1'b0, 1'b0, 2, 10);
        chk("t4.cov1", 0, 32'(cov_o[0]), 32'h1);
        apply_vec(0, 1'b1, 1'b0, 0, 10);
        apply_vec(0, 1'b0, 1'b1, 0, 10);
        apply_vec(0, 1'b1, 1'b1, 0, 10);
        chk("t4.pass", 0, 32'(pass_o[0]), 32'd0);

        // Reset on the second SETTLE cycle.
        start_run(0, 1'b0);
        @(negedge clk);
        a_s[0]  = 1'b1;
        b_s[0]  = 1'b0;
        vv_s[0] = 1'b1;
        @(negedge clk);
        vv_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset_all();
        for (int i = 0; i < 3; i++) check_all(i, 1'b0, "midrst");
        start_run(0, 1'b0);
        full_seq(0, 7);
        chk("t5.pass", 0, 32'(pass_o[0]), 32'd1);

        // Settle 0: done two cycles after the fourth vector.
        start_run(2, 1'b0);
        full_seq(2, 4);
        chk("t6.pass", 2, 32'(pass_o[2]), 32'd1);
        // start together with vec_valid in DONE: start wins.
        start_run(2, 1'b1);
        full_seq(2, 2);

        // Randomized runs with random faults, orders, repeats and overruns.
        for (int it = 0; it < 8; it++) begin
            k = ($urandom_range(0, 1) == 0) ? 0 : 2;
            s = settle_c[k];
            sa0_m[k] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
            inv_m[k] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
            start_run(k, 1'($urandom_range(0, 1)));
            steps = 0;
            while (!m_done[k]) begin
                if (steps < 8) vec = $urandom_range(0, 3);
                else           vec = (steps - 8) % 4;
                extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, s + 1) : 0;
                apply_vec(k, vec[0], vec[1], extra, s + 2 + $urandom_range(0, 3));
                steps++;
            end
            apply_vec(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
